// File: rtl/lasint_pkg.sv
// Shared types and widths for the laser-interferometer readout controller.
package lasint_pkg;

  localparam int POS_W = 32;
  localparam int TAG_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ZERO   = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } state_t;

endpackage

// File: rtl/lasint_rr_arb2.sv
// Two-requester round-robin arbiter; priority moves past the last grantee.
module lasint_rr_arb2 (
  input  logic       clock,
  input  logic       reset_c,
  input  logic [1:0] elig,
  output logic [1:0] gnt
);

  logic pri;

  always_comb begin
    gnt = elig;
    if (elig == 2'b11) gnt = pri ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clock or negedge reset_c) begin
    if (!reset_c)    pri <= 1'b0;
    else if (gnt[0]) pri <= 1'b1;
    else if (gnt[1]) pri <= 1'b0;
  end

endmodule

// File: rtl/lasint_readout_ctrl.sv
// Position-counter readout: zero/settle sequencing, periodic snapshot, 2-port read.
// Optional counter-wrap detection is built when LASINT_WRAP_DETECT_EN is defined.
//
// state  | meaning
// IDLE   | no sampling, snapshot retained, reads allowed
// ZERO   | cnt_reset held high for ZERO_CYC cycles
// SETTLE | quiet period for trigger-chain latency
// RUN    | periodic capture of pos_in every sample_div+1 cycles
module lasint_readout_ctrl
  import lasint_pkg::*;
#(
  parameter int ZERO_CYC   = 4,
  parameter int SETTLE_CYC = 6,
  parameter int DIV_W      = 16
) (
  input  logic             clock,
  input  logic             reset_c,
  input  logic             zero_req,
  input  logic             run_en,
  input  logic [DIV_W-1:0] sample_div,
  input  logic [POS_W-1:0] pos_in,
  output logic             cnt_reset,
  input  logic [1:0]       req,
  output logic [1:0]       gnt,
  output logic [POS_W-1:0] rd_data,
  output logic             rd_valid,
  output logic [TAG_W-1:0] smp_tag,
  output logic             busy,
  output logic             wrap_flag
);

  localparam int TMR_MAX = (ZERO_CYC > SETTLE_CYC) ? ZERO_CYC : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] ZERO_LD   = TMR_W'(ZERO_CYC - 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);

  state_t             state, state_nx;
  logic [TMR_W-1:0]   tmr, tmr_nx;
  logic [DIV_W-1:0]   smp_cnt;
  logic [POS_W-1:0]   snap;
  logic [TAG_W-1:0]   tag;
  logic [1:0]         fresh;
  logic [1:0]         elig;
  logic               capture;

  always_ff @(posedge clock or negedge reset_c) begin
    if (!reset_c) begin
      state <= ZERO;
      tmr   <= ZERO_LD;
    end else begin
      state <= state_nx;
      tmr   <= tmr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    tmr_nx   = tmr;
    case (state)
      IDLE: begin
        if (zero_req) begin
          state_nx = ZERO;
          tmr_nx   = ZERO_LD;
        end else if (run_en) begin
          state_nx = RUN;
        end
      end
      ZERO: begin
        if (zero_req) begin
          tmr_nx = ZERO_LD;
        end else if (tmr == '0) begin
          state_nx = SETTLE;
          tmr_nx   = SETTLE_LD;
        end else begin
          tmr_nx = tmr - 1'b1;
        end
      end
      SETTLE: begin
        if (zero_req) begin
          state_nx = ZERO;
          tmr_nx   = ZERO_LD;
        end else if (tmr == '0) begin
          state_nx = run_en ? RUN : IDLE;
        end else begin
          tmr_nx = tmr - 1'b1;
        end
      end
      RUN: begin
        if (zero_req) begin
          state_nx = ZERO;
          tmr_nx   = ZERO_LD;
        end else if (!run_en) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = ZERO;
        tmr_nx   = ZERO_LD;
      end
    endcase
  end

  // Counter idles at sample_div outside RUN so RUN entry starts a full period.
  assign capture = (state == RUN) && (smp_cnt == '0) && !zero_req;

  always_ff @(posedge clock or negedge reset_c) begin
    if (!reset_c)                      smp_cnt <= '0;
    else if (state != RUN || capture)  smp_cnt <= sample_div;
    else                               smp_cnt <= smp_cnt - 1'b1;
  end

  assign elig = req & fresh & {2{state != ZERO}};

  lasint_rr_arb2 u_arb (
    .clock   (clock),
    .reset_c (reset_c),
    .elig    (elig),
    .gnt     (gnt)
  );

  // A capture re-arms both readers, overriding a same-cycle grant clear.
  always_ff @(posedge clock or negedge reset_c) begin
    if (!reset_c) begin
      snap  <= '0;
      tag   <= '0;
      fresh <= 2'b00;
    end else if (zero_req) begin
      snap  <= '0;
      tag   <= '0;
      fresh <= 2'b00;
    end else if (capture) begin
      snap  <= pos_in;
      tag   <= tag + 1'b1;
      fresh <= 2'b11;
    end else begin
      fresh <= fresh & ~gnt;
    end
  end

`ifdef LASINT_WRAP_DETECT_EN
  logic wrap_q;
  logic wrap_hit;

  assign wrap_hit = ((snap[POS_W-1:POS_W-2] == 2'b01) && (pos_in[POS_W-1:POS_W-2] == 2'b10)) ||
                    ((snap[POS_W-1:POS_W-2] == 2'b10) && (pos_in[POS_W-1:POS_W-2] == 2'b01));

  always_ff @(posedge clock or negedge reset_c) begin
    if (!reset_c)                 wrap_q <= 1'b0;
    else if (zero_req)            wrap_q <= 1'b0;
    else if (capture && wrap_hit) wrap_q <= 1'b1;
  end

  assign wrap_flag = wrap_q;
`else
  assign wrap_flag = 1'b0;
`endif

  assign cnt_reset = (state == ZERO);
  assign busy      = (state == ZERO) || (state == SETTLE);
  assign rd_valid  = |gnt;
  assign rd_data   = snap;
  assign smp_tag   = tag;

endmodule

// File: tb/tb_lasint_readout_ctrl.sv
// Self-checking bench for lasint_readout_ctrl (honours LASINT_WRAP_DETECT_EN).
module tb_lasint_readout_ctrl;

  logic        clock = 1'b0;
  logic        reset_c = 1'b0;
  logic        zero_req = 1'b0;
  logic        run_en = 1'b0;
  logic [15:0] sample_div = 16'd0;
  logic [31:0] pos_in = 32'd0;
  logic        cnt_reset;
  logic [1:0]  req = 2'b00;
  logic [1:0]  gnt;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [7:0]  smp_tag;
  logic        busy;
  logic        wrap_flag;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  lasint_readout_ctrl #(.ZERO_CYC(4), .SETTLE_CYC(6), .DIV_W(16)) dut (
    .clock      (clock),
    .reset_c    (reset_c),
    .zero_req   (zero_req),
    .run_en     (run_en),
    .sample_div (sample_div),
    .pos_in     (pos_in),
    .cnt_reset  (cnt_reset),
    .req        (req),
    .gnt        (gnt),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .smp_tag    (smp_tag),
    .busy       (busy),
    .wrap_flag  (wrap_flag)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        run_en;
    logic [1:0]  req;
    logic [31:0] pos;
    logic [1:0]  gnt;
    logic [31:0] data;
    logic [7:0]  tag;
  } vec_t;

  vec_t tbl [18];

`ifdef LASINT_WRAP_DETECT_EN
  localparam logic WRAP_EXP = 1'b1;
`else
  localparam logic WRAP_EXP = 1'b0;
`endif

  initial begin
    int zero_n, busy_n, first_run, g_n, found;
    int g_w [3];
    logic [31:0] g_d [3];
    logic [7:0]  g_t [3];

    // Window starts at RUN entry + 1 with sample_div=1 (capture every other cycle).
    tbl[0]  = '{1'b1, 2'b00, 32'd100, 2'b00, 32'd0,   8'd0};
    tbl[1]  = '{1'b1, 2'b11, 32'd0,   2'b01, 32'd100, 8'd1};
    tbl[2]  = '{1'b1, 2'b11, 32'd104, 2'b10, 32'd100, 8'd1};
    tbl[3]  = '{1'b1, 2'b11, 32'd0,   2'b01, 32'd104, 8'd2};
    tbl[4]  = '{1'b1, 2'b11, 32'd108, 2'b10, 32'd104, 8'd2};
    tbl[5]  = '{1'b1, 2'b01, 32'd0,   2'b01, 32'd108, 8'd3};
    tbl[6]  = '{1'b1, 2'b00, 32'd112, 2'b00, 32'd0,   8'd3};
    tbl[7]  = '{1'b1, 2'b10, 32'd0,   2'b10, 32'd112, 8'd4};
    tbl[8]  = '{1'b1, 2'b10, 32'd116, 2'b00, 32'd0,   8'd4};
    tbl[9]  = '{1'b1, 2'b10, 32'd0,   2'b10, 32'd116, 8'd5};
    tbl[10] = '{1'b1, 2'b11, 32'd120, 2'b01, 32'd116, 8'd5};
    tbl[11] = '{1'b0, 2'b11, 32'd0,   2'b10, 32'd120, 8'd6};
    tbl[12] = '{1'b0, 2'b01, 32'd0,   2'b01, 32'd120, 8'd6};
    tbl[13] = '{1'b0, 2'b11, 32'd0,   2'b00, 32'd0,   8'd6};
    tbl[14] = '{1'b1, 2'b00, 32'd0,   2'b00, 32'd0,   8'd6};
    tbl[15] = '{1'b1, 2'b00, 32'd0,   2'b00, 32'd0,   8'd6};
    tbl[16] = '{1'b1, 2'b00, 32'd200, 2'b00, 32'd0,   8'd6};
    tbl[17] = '{1'b1, 2'b10, 32'd0,   2'b10, 32'd200, 8'd7};

    // Held in reset with requests pending.
    run_en = 1'b1; sample_div = 16'd3; req = 2'b11;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_cnt_reset", 32'(cnt_reset), 32'd1);
    chk("rst_busy",      32'(busy),      32'd1);
    chk("rst_gnt",       32'(gnt),       32'd0);
    chk("rst_rd_valid",  32'(rd_valid),  32'd0);
    chk("rst_tag",       32'(smp_tag),   32'd0);
    chk("rst_wrap",      32'(wrap_flag), 32'd0);

    // Reset release, ramping pos_in, requester 0 reading each sample.
    zero_n = 0; busy_n = 0; first_run = -1; g_n = 0;
    for (int w = 0; w < 23; w++) begin
      @(negedge clock);
      reset_c = 1'b1; req = 2'b01; pos_in = 32'(1000 + w);
      #1;
      if (cnt_reset) zero_n++;
      if (busy) busy_n++;
      else if (first_run < 0) first_run = w;
      if (rd_valid) begin
        if (g_n < 3) begin
          g_w[g_n] = w; g_d[g_n] = rd_data; g_t[g_n] = smp_tag;
        end
        g_n++;
      end
    end
    chk("seq_cnt_reset_cycles", 32'(zero_n), 32'd4);
    chk("seq_busy_cycles",      32'(busy_n), 32'd10);
    chk("seq_first_run_cycle",  32'(first_run), 32'd10);
    chk("seq_grant_count",      32'(g_n), 32'd3);
    if (g_n >= 3) begin
      for (int k = 0; k < 3; k++) begin
        chk("seq_grant_cycle", 32'(g_w[k]), 32'(14 + 4 * k));
        chk("seq_grant_data",  g_d[k], 32'(1013 + 4 * k));
        chk("seq_grant_tag",   32'(g_t[k]), 32'(k + 1));
      end
    end

    // Fresh reset, sample_div=1, run until RUN entry then replay the table.
    @(negedge clock);
    reset_c = 1'b0; req = 2'b00; sample_div = 16'd1; run_en = 1'b1;
    #1 reset_c = 1'b1;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      #1;
      if (!busy) begin found = 1; break; end
    end
    chk("tbl_reach_run", 32'(found), 32'd1);
    for (int i = 0; i < 18; i++) begin
      @(negedge clock);
      run_en = tbl[i].run_en; req = tbl[i].req; pos_in = tbl[i].pos;
      #1;
      chk("tbl_gnt",      32'(gnt),      32'(tbl[i].gnt));
      chk("tbl_rd_valid", 32'(rd_valid), 32'(|tbl[i].gnt));
      chk("tbl_tag",      32'(smp_tag),  32'(tbl[i].tag));
      chk("tbl_busy",     32'(busy),     32'd0);
      if (tbl[i].gnt != 2'b00) chk("tbl_rd_data", rd_data, tbl[i].data);
    end

    // One more capture sets both fresh bits, then zero_req with a restart inside ZERO.
    @(negedge clock);
    req = 2'b00; pos_in = 32'd300;
    @(negedge clock);
    zero_req = 1'b1;
    #1 chk("zr_tag_before", 32'(smp_tag), 32'd8);
    zero_n = 0; busy_n = 0; g_n = 0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clock);
      zero_req = (j == 2); req = 2'b11; pos_in = 32'(500 + j);
      #1;
      if (j == 0) chk("zr_tag_cleared", 32'(smp_tag), 32'd0);
      if (cnt_reset) zero_n++;
      if (busy) busy_n++;
      if (j < 15 && gnt != 2'b00) g_n++;
      if (j == 15) begin
        chk("zr_post_gnt",  32'(gnt),     32'd1);
        chk("zr_post_data", rd_data,      32'd514);
        chk("zr_post_tag",  32'(smp_tag), 32'd1);
      end
    end
    chk("zr_no_grants",         32'(g_n),    32'd0);
    chk("zr_cnt_reset_cycles",  32'(zero_n), 32'd7);
    chk("zr_busy_cycles",       32'(busy_n), 32'd13);

    // Counter wrap across the sign boundary.
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      req = 2'b00; pos_in = 32'h7FFF_FFF0;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      pos_in = 32'h8000_0005;
      if (k == 0) begin
        #1 chk("wrap_before", 32'(wrap_flag), 32'd0);
      end
    end
    @(negedge clock);
    zero_req = 1'b1;
    #1 chk("wrap_after", 32'(wrap_flag), 32'(WRAP_EXP));
    @(negedge clock);
    zero_req = 1'b0;
    #1 chk("wrap_cleared", 32'(wrap_flag), 32'd0);

    // Reset asserted while a grant is being presented.
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      req = 2'b11; pos_in = 32'd777;
      #1;
      if (rd_valid) begin found = 1; break; end
    end
    chk("mid_rst_grant_seen", 32'(found), 32'd1);
    #1 reset_c = 1'b0;
    #1;
    chk("mid_rst_gnt",       32'(gnt),       32'd0);
    chk("mid_rst_rd_valid",  32'(rd_valid),  32'd0);
    chk("mid_rst_busy",      32'(busy),      32'd1);
    chk("mid_rst_cnt_reset", 32'(cnt_reset), 32'd1);
    chk("mid_rst_tag",       32'(smp_tag),   32'd0);
    @(negedge clock);
    reset_c = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
